// File: rtl/shift_unit_if.sv
// Request/result handshake bundle for shift_unit: operand, shift amount and mode
// in, result with carry/zero flags out, each side with its own valid/ready pair.
interface shift_unit_if #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = $clog2(WIDTH)
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic [SHAMT_W-1:0] in_shamt;
  logic [1:0]         in_mode;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic               out_carry;
  logic               out_zero;

  modport master (
    output in_valid, in_data, in_shamt, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_carry, out_zero
  );

  modport slave (
    input  in_valid, in_data, in_shamt, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_carry, out_zero
  );
endinterface

// File: rtl/shift_unit.sv
// shift_unit: multi-cycle LSL/LSR/ASR/ROL unit, STEP bits per clock, carry/zero flags.
// Define SHIFT_UNIT_BARREL_EN to compute the whole shift at accept (one-edge latency).
module shift_unit #(
  parameter int WIDTH   = 8,
  parameter int STEP    = 1,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input logic         clk,
  input logic         rst_n,
  shift_unit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t             state_r, state_next_s;
  logic [WIDTH-1:0]   data_r, data_next_s;
  logic [1:0]         mode_r, mode_next_s;
  logic [SHAMT_W-1:0] rem_r, rem_next_s;
  logic               carry_r, carry_next_s;
  logic               zero_r;
  logic               in_ready_r;
  logic               out_valid_r;
  logic               accept_s;
  logic [WIDTH-1:0]   calc_data_s;
  logic               calc_carry_s;
  logic [SHAMT_W-1:0] calc_rem_s;

  // One-bit move; returns {bit that left or wrapped, shifted data}.
  function automatic logic [WIDTH:0] shift1(input logic [WIDTH-1:0] d, input logic [1:0] m);
    logic [WIDTH:0] r;
    case (m)
      2'b00:   r = {d[WIDTH-1], d[WIDTH-2:0], 1'b0};
      2'b01:   r = {d[0], 1'b0, d[WIDTH-1:1]};
      2'b10:   r = {d[0], d[WIDTH-1], d[WIDTH-1:1]};
      2'b11:   r = {d[WIDTH-1], d[WIDTH-2:0], d[WIDTH-1]};
      default: r = {1'b0, d};
    endcase
    return r;
  endfunction

  // in_ready_r is only ever high in IDLE, so it doubles as the accept qualifier.
  assign accept_s = in_ready_r & bus.in_valid;

`ifdef SHIFT_UNIT_BARREL_EN
  // Whole shift of the incoming operand, bit by bit until the amount is used up.
  always_comb begin
    calc_data_s  = bus.in_data;
    calc_carry_s = 1'b0;
    calc_rem_s   = bus.in_shamt;
    for (int i = 0; i < WIDTH - 1; i++) begin
      if (calc_rem_s != {SHAMT_W{1'b0}}) begin
        {calc_carry_s, calc_data_s} = shift1(calc_data_s, bus.in_mode);
        calc_rem_s = calc_rem_s - SHAMT_W'(1);
      end else begin
        calc_rem_s = calc_rem_s;
      end
    end
  end
`else
  // Up to STEP single-bit moves of the working register; stops early at remaining=0.
  always_comb begin
    calc_data_s  = data_r;
    calc_carry_s = carry_r;
    calc_rem_s   = rem_r;
    for (int i = 0; i < STEP; i++) begin
      if (calc_rem_s != {SHAMT_W{1'b0}}) begin
        {calc_carry_s, calc_data_s} = shift1(calc_data_s, mode_r);
        calc_rem_s = calc_rem_s - SHAMT_W'(1);
      end else begin
        calc_rem_s = calc_rem_s;
      end
    end
  end
`endif

  // Next-state and datapath update.
  always_comb begin
    state_next_s = state_r;
    data_next_s  = data_r;
    mode_next_s  = mode_r;
    rem_next_s   = rem_r;
    carry_next_s = carry_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          mode_next_s = bus.in_mode;
`ifdef SHIFT_UNIT_BARREL_EN
          data_next_s  = calc_data_s;
          carry_next_s = calc_carry_s;
          rem_next_s   = {SHAMT_W{1'b0}};
          state_next_s = DONE;
`else
          data_next_s  = bus.in_data;
          carry_next_s = 1'b0;
          rem_next_s   = bus.in_shamt;
          state_next_s = (bus.in_shamt != {SHAMT_W{1'b0}}) ? SHIFT : DONE;
`endif
        end else begin
          state_next_s = IDLE;
        end
      end
      SHIFT: begin
        data_next_s  = calc_data_s;
        carry_next_s = calc_carry_s;
        rem_next_s   = calc_rem_s;
        state_next_s = (calc_rem_s == {SHAMT_W{1'b0}}) ? DONE : SHIFT;
      end
      DONE: begin
        if (bus.out_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = DONE;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State and output registers; handshake flags are decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      data_r      <= {WIDTH{1'b0}};
      mode_r      <= 2'b00;
      rem_r       <= {SHAMT_W{1'b0}};
      carry_r     <= 1'b0;
      zero_r      <= 1'b0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      data_r      <= data_next_s;
      mode_r      <= mode_next_s;
      rem_r       <= rem_next_s;
      carry_r     <= carry_next_s;
      zero_r      <= (data_next_s == {WIDTH{1'b0}});
      in_ready_r  <= (state_next_s == IDLE);
      out_valid_r <= (state_next_s == DONE);
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = data_r;
  assign bus.out_carry = carry_r;
  assign bus.out_zero  = zero_r;

endmodule

// File: tb/tb_shift_unit.sv
// Directed-vector bench for shift_unit: WIDTH=6/STEP=1 table, WIDTH=8/STEP=2 latency,
// DONE backpressure, and asynchronous reset in the middle of a shift (WIDTH=8/STEP=1).
module tb_shift_unit;
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  shift_unit_if #(.WIDTH(6)) b6 ();
  shift_unit_if #(.WIDTH(8)) b8 ();
  shift_unit_if #(.WIDTH(8)) b81 ();

  shift_unit #(.WIDTH(6), .STEP(1)) u6  (.clk(clk), .rst_n(rst_n), .bus(b6));
  shift_unit #(.WIDTH(8), .STEP(2)) u8  (.clk(clk), .rst_n(rst_n), .bus(b8));
  shift_unit #(.WIDTH(8), .STEP(1)) u81 (.clk(clk), .rst_n(rst_n), .bus(b81));

  typedef struct {
    logic [5:0] data;
    logic [1:0] mode;
    logic [2:0] shamt;
    logic [5:0] exp_data;
    logic       exp_carry;
    logic       exp_zero;
    int         exp_lat;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic int lat_of(input int iter_lat);
`ifdef SHIFT_UNIT_BARREL_EN
    return 0;
`else
    return iter_lat;
`endif
  endfunction

  // Full transaction on the WIDTH=6 unit; lat counts edges after the accept edge.
  task automatic run6(input logic [5:0] d, input logic [1:0] m, input logic [2:0] s,
                      output logic [5:0] od, output logic oc, output logic oz, output int lat);
    int n = 0;
    while (!b6.in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    b6.in_data  = d;
    b6.in_mode  = m;
    b6.in_shamt = s;
    b6.in_valid = 1'b1;
    @(posedge clk); #1;
    b6.in_valid = 1'b0;
    lat = 0;
    while (!b6.out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    od = b6.out_data;
    oc = b6.out_carry;
    oz = b6.out_zero;
    b6.out_ready = 1'b1;
    @(posedge clk); #1;
    b6.out_ready = 1'b0;
  endtask

  initial begin
    logic [5:0] od;
    logic       oc, oz;
    int         lat;

    vecs[0]  = '{6'b001000, 2'b00, 3'd2, 6'b100000, 1'b0, 1'b0, 2};
    vecs[1]  = '{6'b001000, 2'b01, 3'd3, 6'b000001, 1'b0, 1'b0, 3};
    vecs[2]  = '{6'b101100, 2'b10, 3'd3, 6'b111101, 1'b1, 1'b0, 3};
    vecs[3]  = '{6'b100001, 2'b11, 3'd2, 6'b000110, 1'b0, 1'b0, 2};
    vecs[4]  = '{6'b111000, 2'b00, 3'd3, 6'b000000, 1'b1, 1'b1, 3};
    vecs[5]  = '{6'b101101, 2'b00, 3'd0, 6'b101101, 1'b0, 1'b0, 0};
    vecs[6]  = '{6'b101101, 2'b10, 3'd0, 6'b101101, 1'b0, 1'b0, 0};
    vecs[7]  = '{6'b000000, 2'b11, 3'd0, 6'b000000, 1'b0, 1'b1, 0};
    vecs[8]  = '{6'b010011, 2'b11, 3'd5, 6'b101001, 1'b1, 1'b0, 5};
    vecs[9]  = '{6'b100000, 2'b01, 3'd5, 6'b000001, 1'b0, 1'b0, 5};
    vecs[10] = '{6'b100000, 2'b10, 3'd5, 6'b111111, 1'b0, 1'b0, 5};
    vecs[11] = '{6'b000011, 2'b01, 3'd2, 6'b000000, 1'b1, 1'b1, 2};

    b6.in_valid = 1'b0;  b6.in_data = '0;  b6.in_shamt = '0;  b6.in_mode = 2'b00;  b6.out_ready = 1'b0;
    b8.in_valid = 1'b0;  b8.in_data = '0;  b8.in_shamt = '0;  b8.in_mode = 2'b00;  b8.out_ready = 1'b0;
    b81.in_valid = 1'b0; b81.in_data = '0; b81.in_shamt = '0; b81.in_mode = 2'b00; b81.out_ready = 1'b0;

    // Reset values while rst_n is held low across clock edges.
    #1 rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("rst in_ready", 32'(b6.in_ready), 32'd0);
    check("rst out_valid", 32'(b6.out_valid), 32'd0);
    check("rst out_data", 32'(b6.out_data), 32'd0);
    check("rst out_carry", 32'(b6.out_carry), 32'd0);
    check("rst out_zero", 32'(b6.out_zero), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("first edge in_ready", 32'(b6.in_ready), 32'd1);

    for (int i = 0; i < 12; i++) begin
      run6(vecs[i].data, vecs[i].mode, vecs[i].shamt, od, oc, oz, lat);
      check($sformatf("vec%0d data", i), 32'(od), 32'(vecs[i].exp_data));
      check($sformatf("vec%0d carry", i), 32'(oc), 32'(vecs[i].exp_carry));
      check($sformatf("vec%0d zero", i), 32'(oz), 32'(vecs[i].exp_zero));
      check($sformatf("vec%0d latency", i), 32'(lat), 32'(lat_of(vecs[i].exp_lat)));
    end

    // WIDTH=8, STEP=2: 8'h01 LSL 5 takes three SHIFT cycles.
    check("w8 in_ready", 32'(b8.in_ready), 32'd1);
    b8.in_data = 8'h01; b8.in_mode = 2'b00; b8.in_shamt = 3'd5; b8.in_valid = 1'b1;
    @(posedge clk); #1;
    b8.in_valid = 1'b0;
    lat = 0;
    while (!b8.out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    check("w8 data", 32'(b8.out_data), 32'h20);
    check("w8 carry", 32'(b8.out_carry), 32'd0);
    check("w8 zero", 32'(b8.out_zero), 32'd0);
    check("w8 latency", 32'(lat), 32'(lat_of(3)));
    b8.out_ready = 1'b1;
    @(posedge clk); #1;
    b8.out_ready = 1'b0;
    check("w8 back to idle", 32'(b8.out_valid), 32'd0);

    // Backpressure: result held for four cycles while in_valid pulses are ignored.
    b6.in_data = 6'b000111; b6.in_mode = 2'b00; b6.in_shamt = 3'd1; b6.in_valid = 1'b1;
    @(posedge clk); #1;
    b6.in_valid = 1'b0;
    lat = 0;
    while (!b6.out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    check("bp latency", 32'(lat), 32'(lat_of(1)));
    for (int c = 0; c < 4; c++) begin
      b6.in_valid = c[0] ? 1'b0 : 1'b1;
      b6.in_data  = 6'b111111;
      b6.in_shamt = 3'd0;
      @(posedge clk); #1;
      check($sformatf("bp%0d out_valid", c), 32'(b6.out_valid), 32'd1);
      check($sformatf("bp%0d out_data", c), 32'(b6.out_data), 32'b001110);
      check($sformatf("bp%0d out_carry", c), 32'(b6.out_carry), 32'd0);
      check($sformatf("bp%0d in_ready", c), 32'(b6.in_ready), 32'd0);
    end
    b6.in_valid  = 1'b0;
    b6.out_ready = 1'b1;
    @(posedge clk); #1;
    b6.out_ready = 1'b0;
    check("bp release out_valid", 32'(b6.out_valid), 32'd0);
    check("bp release in_ready", 32'(b6.in_ready), 32'd1);
    run6(6'b110011, 2'b01, 3'd1, od, oc, oz, lat);
    check("bp next data", 32'(od), 32'b011001);
    check("bp next carry", 32'(oc), 32'd1);
    check("bp next zero", 32'(oz), 32'd0);
    check("bp next latency", 32'(lat), 32'(lat_of(1)));

    // Asynchronous reset three cycles into a WIDTH=8, shamt=7 shift.
    b81.in_data = 8'hB5; b81.in_mode = 2'b00; b81.in_shamt = 3'd7; b81.in_valid = 1'b1;
    @(posedge clk); #1;
    b81.in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    check("abort out_valid", 32'(b81.out_valid), 32'd0);
    check("abort in_ready", 32'(b81.in_ready), 32'd0);
    check("abort out_data", 32'(b81.out_data), 32'd0);
    check("abort out_carry", 32'(b81.out_carry), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("abort recover in_ready", 32'(b81.in_ready), 32'd1);
    b81.in_data = 8'hB5; b81.in_mode = 2'b00; b81.in_shamt = 3'd7; b81.in_valid = 1'b1;
    @(posedge clk); #1;
    b81.in_valid = 1'b0;
    lat = 0;
    while (!b81.out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    check("fresh data", 32'(b81.out_data), 32'h80);
    check("fresh carry", 32'(b81.out_carry), 32'd0);
    check("fresh zero", 32'(b81.out_zero), 32'd0);
    check("fresh latency", 32'(lat), 32'(lat_of(7)));
    b81.out_ready = 1'b1;
    @(posedge clk); #1;
    b81.out_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
